bcd2bin: RTL and testbench
==========================

BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD digits converted; only value 4 is supported.
REQ-002 SHALL have port pixel_clk_in, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port data_valid_in, input, 1 bit: request to convert bcd_in.
REQ-005 SHALL have port bcd_in, input, 16 bits: digits d3..d0 at [15:12], [11:8], [7:4], [3:0], with d3 the thousands digit.
REQ-006 SHALL have port busy_out, output, 1 bit: a conversion is in progress and inputs are ignored.
REQ-007 SHALL have port bin_out, output, 14 bits: the binary result.
REQ-008 SHALL have port data_valid_out, output, 1 bit: bin_out/error_out are valid, as a single-cycle pulse.
REQ-009 SHALL have port error_out, output, 1 bit: the captured input held an invalid digit.

Function
REQ-010 SHALL use FSM states IDLE, SHIFT and DONE.
REQ-011 SHALL, in IDLE with data_valid_in=1 at edge k:
- capture bcd_in into bits [31:16] of a 32-bit work register;
- clear the work register's low 16 bits;
- clear the 5-bit iteration counter;
- go to SHIFT;
- set busy_out=1 after edge k.
REQ-012 SHALL, on each SHIFT edge (edges k+1..k+16), perform one reverse double-dabble step:
- shift the work register right by 1;
- then, for each of the 4 upper nibbles, subtract 3 if that nibble is >=8;
- increment the counter.
REQ-013 SHALL go to DONE after the 16th step (edge k+16).
REQ-014 SHALL, at DONE edge k+17:
- register bin_out = work[13:0] and error_out=0;
- pulse data_valid_out=1 for exactly the cycle after edge k+17;
- clear busy_out in that same cycle;
- return to IDLE.
REQ-015 SHALL set fixed latency to 17 cycles from the accept edge to the edge that raises data_valid_out; a new request is acceptable at edge k+18.
REQ-016 SHALL ignore and drop data_valid_in while busy_out=1, with no queueing and no effect on the conversion in progress.
REQ-017 SHALL hold bin_out and error_out at their last values until the next data_valid_out pulse.
REQ-018 SHALL produce bin_out = (1000*d3 + 100*d2 + 10*d1 + d0) mod 16384 for any nibble values; for a legal BCD input (0..9999) this is exact.
REQ-019 SHALL sample bcd_in only at the accept edge; changes to bcd_in during conversion have no effect.

Reset
REQ-020 SHALL, when rst_in=1 at an edge, force the FSM to IDLE and clear busy_out, data_valid_out, error_out, bin_out, the counter and the work register, overriding all other activity.
REQ-021 SHALL, on reset mid-conversion, abort the conversion with no data_valid_out pulse for it.
REQ-022 SHALL not accept data_valid_in in the same cycle that rst_in=1; the first acceptable edge is the one after reset deasserts.

Configuration
REQ-023 SHALL support macro BCD2BIN_RANGE_CHECK_EN, which compiles digit range checking in or out.
REQ-024 SHALL, with BCD2BIN_RANGE_CHECK_EN defined, on acceptance with any nibble >9:
- skip SHIFT and go directly to DONE;
- at edge k+1, register bin_out=0 and error_out=1, and pulse data_valid_out;
- clear busy_out in the cycle after edge k+1.
REQ-025 SHALL, with BCD2BIN_RANGE_CHECK_EN undefined, tie error_out to 0 and convert all inputs per REQ-018 with 17-cycle latency.

Verification
REQ-026 SHALL cover: bcd_in=16'h1234 with data_valid_in pulsed at edge 0 -> data_valid_out high only in the cycle after edge 17, bin_out=1234, error_out=0, busy_out high only in the cycles after edges 0..16.
REQ-027 SHALL cover: bcd_in=16'h9999 -> bin_out=9999; bcd_in=16'h0000 -> bin_out=0; both with 17-cycle latency.
REQ-028 SHALL cover: bcd_in=16'h12A4 -> with BCD2BIN_RANGE_CHECK_EN, data_valid_out after edge 1, error_out=1, bin_out=0; without it, bin_out=1304 after edge 17, error_out=0.
REQ-029 SHALL cover: accept 16'h0042, then data_valid_in with 16'h0777 at edge 5 -> exactly one data_valid_out pulse, bin_out=42; a request at edge 18 with 16'h0777 -> bin_out=777 after edge 35.
REQ-030 SHALL cover: accept 16'h5678, assert rst_in at edge 8 -> no data_valid_out pulse, all outputs 0; accept 16'h0010 at edge 10 -> bin_out=10 after edge 27.
REQ-031 SHALL cover: back-to-back requests with data_valid_in held high continuously and bcd_in incrementing -> one conversion per 18 cycles, each result matching the bcd_in value at its accept edge.

Source files
------------

// File: rtl/bcd2bin.sv
// Four-digit BCD to 14-bit binary converter using a serial reverse double-dabble.
// Optional macro BCD2BIN_RANGE_CHECK_EN flags inputs that contain a nibble above 9.
module bcd2bin #(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                      pixel_clk_in,
    input  logic                      rst_in,
    input  logic                      data_valid_in,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    output logic                      busy_out,
    output logic [13:0]               bin_out,
    output logic                      data_valid_out,
    output logic                      error_out
);

    localparam int unsigned BCD_W  = 4 * NUM_DIGITS;
    localparam int unsigned WORK_W = 2 * BCD_W;
    localparam int unsigned BIN_W  = 14;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned STEPS  = BCD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WORK_W-1:0]  work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic [WORK_W-1:0]  step_c;

`ifdef BCD2BIN_RANGE_CHECK_EN
    logic               bad_q, bad_d;
    logic               digit_bad_c;

    // Any nibble outside 0..9 makes the request an error.
    always_comb begin
        digit_bad_c = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                digit_bad_c = 1'b1;
            end
        end
    end
`endif

    // One reverse double-dabble step: halve, then fix nibbles that received a carried-in bit.
    always_comb begin
        step_c = work_q >> 1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (step_c[BCD_W + 4*i +: 4] >= 4'd8) begin
                step_c[BCD_W + 4*i +: 4] = step_c[BCD_W + 4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        bin_d   = bin_q;
        err_d   = err_q;
`ifdef BCD2BIN_RANGE_CHECK_EN
        bad_d   = bad_q;
`endif
        case (state_q)
            IDLE: begin
                if (data_valid_in) begin
                    work_d = {bcd_in, BCD_W'(0)};
                    cnt_d  = CNT_W'(0);
                    busy_d = 1'b1;
`ifdef BCD2BIN_RANGE_CHECK_EN
                    bad_d   = digit_bad_c;
                    state_d = digit_bad_c ? DONE : SHIFT;
`else
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                work_d = step_c;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef BCD2BIN_RANGE_CHECK_EN
                if (bad_q) begin
                    bin_d = BIN_W'(0);
                    err_d = 1'b1;
                end else begin
                    bin_d = work_q[BIN_W-1:0];
                    err_d = 1'b0;
                end
`else
                bin_d = work_q[BIN_W-1:0];
                err_d = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            work_q  <= WORK_W'(0);
            cnt_q   <= CNT_W'(0);
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bin_q   <= BIN_W'(0);
            err_q   <= 1'b0;
`ifdef BCD2BIN_RANGE_CHECK_EN
            bad_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
`ifdef BCD2BIN_RANGE_CHECK_EN
            bad_q   <= bad_d;
`endif
        end
    end

    assign busy_out       = busy_q;
    assign data_valid_out = valid_q;
    assign bin_out        = bin_q;
    assign error_out      = err_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: directed requests push expected results and due edges;
// a negedge monitor pops and checks every data_valid_out pulse.
module tb_bcd2bin;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic        data_valid_in = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic        busy_out;
    logic [13:0] bin_out;
    logic        data_valid_out;
    logic        error_out;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        rst_q;
    logic [13:0] last_bin = 14'd0;
    logic        last_err = 1'b0;

    typedef struct {
        logic [13:0] bin;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    bcd2bin #(.NUM_DIGITS(4)) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_in),
        .data_valid_in  (data_valid_in),
        .bcd_in         (bcd_in),
        .busy_out       (busy_out),
        .bin_out        (bin_out),
        .data_valid_out (data_valid_out),
        .error_out      (error_out)
    );

    always #5 clk = ~clk;

    // Edge counter: during the low phase after edge N, cyc == N.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_in;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each pulse; otherwise checks hold and overdue results.
    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_bin", 32'(bin_out), 32'd0);
            chk("rst_err", 32'(error_out), 32'd0);
            chk("rst_valid", 32'(data_valid_out), 32'd0);
            chk("rst_busy", 32'(busy_out), 32'd0);
            last_bin = 14'd0;
            last_err = 1'b0;
        end else if (data_valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at edge %0d: got bin=%0d err=%0d expected no pulse",
                         cyc, bin_out, error_out);
            end else begin
                e = sb.pop_front();
                chk("latency_edge", 32'(cyc), 32'(e.due));
                chk("bin", 32'(bin_out), 32'(e.bin));
                chk("err", 32'(error_out), 32'(e.err));
            end
            last_bin = bin_out;
            last_err = error_out;
        end else begin
            chk("hold_bin", 32'(bin_out), 32'(last_bin));
            chk("hold_err", 32'(error_out), 32'(last_err));
            if (sb.size() != 0 && cyc > sb[0].due) begin
                checks++;
                errors++;
                $display("FAIL missing_pulse at edge %0d: got no pulse expected one at edge %0d",
                         cyc, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    // Advance to the low phase just before edge e_num.
    task automatic goto_edge(input int e_num);
        while (cyc < e_num - 1) @(negedge clk);
    endtask

    // Drive one request on the next edge; bcd_in is scrambled afterwards.
    task automatic issue(input logic [15:0] bcd, input logic [13:0] eb, input logic ee,
                         input int lat, input logic acc);
        chk("busy_before_req", 32'(busy_out), 32'(!acc));
        data_valid_in = 1'b1;
        bcd_in        = bcd;
        if (acc) sb.push_back('{eb, ee, cyc + 1 + lat});
        @(negedge clk);
        data_valid_in = 1'b0;
        bcd_in        = 16'hFFFF;
    endtask

    logic [13:0] b2b_exp [3];

    initial begin
        b2b_exp[0] = 14'd100;
        b2b_exp[1] = 14'd112;
        b2b_exp[2] = 14'd124;

        // Request held during reset must not be accepted.
        data_valid_in = 1'b1;
        bcd_in        = 16'h1234;
        repeat (2) @(negedge clk);
        rst_in        = 1'b0;
        data_valid_in = 1'b0;

        // 1234 with busy profile over edges 5..22.
        goto_edge(5);
        issue(16'h1234, 14'd1234, 1'b0, 17, 1'b1);
        for (int i = 0; i < 18; i++) begin
            chk("busy_profile", 32'(busy_out), 32'(cyc <= 21));
            @(negedge clk);
        end

        goto_edge(25);
        issue(16'h9999, 14'd9999, 1'b0, 17, 1'b1);
        goto_edge(45);
        issue(16'h0000, 14'd0, 1'b0, 17, 1'b1);

        goto_edge(65);
`ifdef BCD2BIN_RANGE_CHECK_EN
        issue(16'h12A4, 14'd0, 1'b1, 1, 1'b1);
`else
        issue(16'h12A4, 14'd1304, 1'b0, 17, 1'b1);
`endif

        // Request while busy is dropped; the one at k+18 is taken.
        goto_edge(85);
        issue(16'h0042, 14'd42, 1'b0, 17, 1'b1);
        goto_edge(90);
        issue(16'h0777, 14'd0, 1'b0, 17, 1'b0);
        goto_edge(103);
        issue(16'h0777, 14'd777, 1'b0, 17, 1'b1);

        // Reset mid-conversion aborts it.
        goto_edge(125);
        issue(16'h5678, 14'd5678, 1'b0, 17, 1'b1);
        goto_edge(133);
        rst_in = 1'b1;
        sb.delete();
        @(negedge clk);
        rst_in = 1'b0;
        goto_edge(135);
        issue(16'h0010, 14'd10, 1'b0, 17, 1'b1);

        // Back-to-back: valid held high, bcd_in incrementing every cycle.
        goto_edge(160);
        for (int i = 0; i < 37; i++) begin
            data_valid_in = 1'b1;
            bcd_in        = 16'h0100 + 16'(i);
            if (i % 18 == 0) sb.push_back('{b2b_exp[i / 18], 1'b0, cyc + 18});
            @(negedge clk);
        end
        data_valid_in = 1'b0;

        goto_edge(220);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
